mem_wb_stage: RTL and testbench

MEM-stage controller and MEM/WB pipeline buffer. It consumes the fields driven out of the EX/MEM buffer and resolves the branch decision. It performs the data-memory access over a variable-latency req/ack bus, stalling upstream while the access is outstanding. It then registers the results toward write-back with a one-cycle valid pulse.

---
 rtl/mem_wb_stage.sv | 146 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage controller and MEM/WB pipeline buffer.
// Resolves the branch, runs the data-memory access over a req/ack bus with a
// bounded wait, and registers results toward write-back with a one-cycle valid.
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [2:0]        in_M,
  input  logic [1:0]        in_WB,
  input  logic [DATA_W-1:0] in_add,
  input  logic              in_flag,
  input  logic [DATA_W-1:0] in_res,
  input  logic [DATA_W-1:0] in_dat2,
  input  logic [4:0]        in_mux,
  output logic              stall,
  output logic              pcsrc,
  output logic [DATA_W-1:0] br_target,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              ou_valid,
  output logic [1:0]        ou_WB,
  output logic [DATA_W-1:0] ou_rdata,
  output logic [DATA_W-1:0] ou_res,
  output logic [4:0]        ou_mux,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       hold_wb;
  logic [4:0]       hold_mux;
  logic             accept, mem_op, aligned, timed_out;

  assign accept    = (state == IDLE) && in_valid;
  assign mem_op    = in_M[1] | in_M[0];
  assign aligned   = (in_res[1:0] == 2'b00);
  // The last wait cycle gives up only if the ack has not arrived on it.
  assign timed_out = (state == ACCESS) && !mem_ack && (cnt == CNT_W'(TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: only an aligned memory op leaves IDLE; ack or timeout returns.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && mem_op && aligned) state_nxt = ACCESS;
      ACCESS:  if (mem_ack || timed_out)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall output: hold upstream for the whole access, including the accept cycle.
  always_comb begin
    stall = 1'b0;
    if (state == ACCESS)                          stall = 1'b1;
    else if (in_valid && mem_op && aligned)       stall = 1'b1;
  end

  // Branch pulse, bus drive, wait counter and MEM/WB buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcsrc     <= 1'b0;
      br_target <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ou_valid  <= 1'b0;
      ou_WB     <= '0;
      ou_rdata  <= '0;
      ou_res    <= '0;
      ou_mux    <= '0;
      mem_err   <= 1'b0;
      cnt       <= '0;
      hold_wb   <= '0;
      hold_mux  <= '0;
    end else begin
      pcsrc    <= 1'b0;
      ou_valid <= 1'b0;
      if (accept) begin
        if (in_M[2] && in_flag) begin
          pcsrc     <= 1'b1;
          br_target <= in_add;
        end
        if (!mem_op) begin
          ou_valid <= 1'b1;
          ou_WB    <= in_WB;
          ou_res   <= in_res;
          ou_mux   <= in_mux;
        end else if (!aligned) begin
          // Misaligned: never reaches the bus, result must not be written back.
          mem_err  <= 1'b1;
          ou_valid <= 1'b1;
          ou_WB    <= {1'b0, in_WB[0]};
          ou_res   <= in_res;
          ou_mux   <= in_mux;
        end else begin
          // mem_we follows MemWrite alone, so a write wins over a read.
          mem_req   <= 1'b1;
          mem_we    <= in_M[0];
          mem_addr  <= in_res;
          mem_wdata <= in_dat2;
          hold_wb   <= in_WB;
          hold_mux  <= in_mux;
          cnt       <= CNT_W'(1);
        end
      end else if (state == ACCESS) begin
        if (mem_ack) begin
          mem_req  <= 1'b0;
          ou_valid <= 1'b1;
          ou_WB    <= hold_wb;
          ou_res   <= mem_addr;
          ou_mux   <= hold_mux;
          if (!mem_we) ou_rdata <= mem_rdata;
          cnt      <= '0;
        end else if (timed_out) begin
          mem_req  <= 1'b0;
          mem_err  <= 1'b1;
          ou_valid <= 1'b1;
          ou_WB    <= {1'b0, hold_wb[0]};
          ou_res   <= mem_addr;
          ou_mux   <= hold_mux;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver issues random and directed
// operations and predicts results; a memory responder and a monitor check them.
module tb_mem_wb_stage;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [2:0]        in_M;
  logic [1:0]        in_WB;
  logic [31:0]       in_add;
  logic              in_flag;
  logic [31:0]       in_res;
  logic [31:0]       in_dat2;
  logic [4:0]        in_mux;
  logic              stall, pcsrc;
  logic [31:0]       br_target;
  logic              mem_req, mem_we;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic              mem_ack;
  logic              ou_valid;
  logic [1:0]        ou_WB;
  logic [31:0]       ou_rdata, ou_res;
  logic [4:0]        ou_mux;
  logic              mem_err;

  mem_wb_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_M(in_M), .in_WB(in_WB),
    .in_add(in_add), .in_flag(in_flag), .in_res(in_res), .in_dat2(in_dat2),
    .in_mux(in_mux), .stall(stall), .pcsrc(pcsrc), .br_target(br_target),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ou_valid(ou_valid), .ou_WB(ou_WB),
    .ou_rdata(ou_rdata), .ou_res(ou_res), .ou_mux(ou_mux), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rdata;
    logic [31:0] res;
    logic [4:0]  mux;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    int          cyc;
  } br_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } req_t;

  exp_t out_q[$];
  br_t  br_q[$];
  req_t req_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state: architectural view of sticky error and last load.
  logic        mdl_err   = 1'b0;
  logic [31:0] mdl_rdata = 32'h0;

  logic rsp_busy  = 1'b0;
  logic rsp_abort = 1'b0;
  int   rsp_n     = 0;
  req_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic garbage(input logic v);
    in_valid = v;
    in_M     = 3'($urandom);
    in_WB    = 2'($urandom);
    in_add   = $urandom;
    in_flag  = 1'($urandom);
    in_res   = $urandom;
    in_dat2  = $urandom;
    in_mux   = 5'($urandom);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    garbage(1'b0);
    #1 chk("stall_idle", 32'(stall), 32'd0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ctrl"}, 32'({stall, pcsrc, mem_req, mem_we, ou_valid, mem_err, ou_WB, ou_mux}), 32'd0);
    chk({name, "_br_target"}, br_target, 32'd0);
    chk({name, "_mem_addr"},  mem_addr,  32'd0);
    chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({name, "_ou_rdata"},  ou_rdata,  32'd0);
    chk({name, "_ou_res"},    ou_res,    32'd0);
  endtask

  // Present one operation while the block is idle and predict its outcome.
  task automatic issue(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] add,
                       input logic flag, input logic [31:0] res, input logic [31:0] dat2,
                       input logic [4:0] mux, input int delay, input logic [31:0] rdata);
    exp_t e;
    req_t r;
    br_t  b;
    logic is_mem, is_al;
    int   lat, wait_cycles;
    @(posedge clk); #1;
    in_valid = 1'b1; in_M = m; in_WB = wb; in_add = add; in_flag = flag;
    in_res = res; in_dat2 = dat2; in_mux = mux;
    is_mem = m[1] | m[0];
    is_al  = (res % 4) == 0;
    e.res = res;
    e.mux = mux;
    wait_cycles = 0;
    if (!is_mem) begin
      e.wb = wb;
      lat  = 1;
    end else if (!is_al) begin
      mdl_err = 1'b1;
      e.wb = {1'b0, wb[0]};
      lat  = 1;
    end else if (delay <= TIMEOUT) begin
      e.wb = wb;
      if (!m[0]) mdl_rdata = rdata;
      lat = delay + 1;
      wait_cycles = delay;
    end else begin
      mdl_err = 1'b1;
      e.wb = {1'b0, wb[0]};
      lat  = TIMEOUT + 1;
      wait_cycles = TIMEOUT;
    end
    e.rdata = mdl_rdata;
    e.err   = mdl_err;
    e.cyc   = cyc + lat;
    out_q.push_back(e);
    if (m[2] && flag) begin
      b.target = add;
      b.cyc    = cyc + 1;
      br_q.push_back(b);
    end
    if (is_mem && is_al) begin
      r.we = m[0]; r.addr = res; r.wdata = dat2; r.rdata = rdata; r.delay = delay;
      req_q.push_back(r);
    end
    #1 chk("stall_accept", 32'(stall), 32'(is_mem && is_al));
    repeat (wait_cycles) begin
      @(posedge clk); #1;
      garbage(1'($urandom));
      #1 chk("stall_access", 32'(stall), 32'd1);
    end
  endtask

  // Memory responder: acks after the requested number of cycles, junk otherwise.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!rsp_busy) begin
          if (req_q.size() == 0) begin
            fail_now("unexpected_mem_req");
            mem_ack = 1'b0;
            continue;
          end
          cur = req_q.pop_front();
          rsp_busy = 1'b1;
          rsp_n = 0;
        end
        rsp_n++;
        chk("mem_we",    32'(mem_we), 32'(cur.we));
        chk("mem_addr",  mem_addr,    cur.addr);
        chk("mem_wdata", mem_wdata,   cur.wdata);
        mem_ack   = (rsp_n == cur.delay);
        mem_rdata = mem_ack ? cur.rdata : $urandom;
      end else begin
        if (rsp_busy) begin
          if (rsp_abort) rsp_abort = 1'b0;
          else chk("mem_req_cycles", 32'(rsp_n), 32'((cur.delay < TIMEOUT) ? cur.delay : TIMEOUT));
          rsp_busy = 1'b0;
        end
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: compare every write-back pulse and branch pulse to the scoreboard.
  initial begin
    exp_t e;
    br_t  b;
    forever begin
      @(negedge clk);
      if (ou_valid) begin
        if (out_q.size() == 0) fail_now("unexpected_ou_valid");
        else begin
          e = out_q.pop_front();
          chk("ou_cycle", 32'(cyc), 32'(e.cyc));
          chk("ou_WB",    32'(ou_WB), 32'(e.wb));
          chk("ou_rdata", ou_rdata, e.rdata);
          chk("ou_res",   ou_res, e.res);
          chk("ou_mux",   32'(ou_mux), 32'(e.mux));
          chk("mem_err",  32'(mem_err), 32'(e.err));
        end
      end
      if (pcsrc) begin
        if (br_q.size() == 0) fail_now("unexpected_pcsrc");
        else begin
          b = br_q.pop_front();
          chk("pcsrc_cycle", 32'(cyc), 32'(b.cyc));
          chk("br_target",   br_target, b.target);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    garbage(1'b0);
    repeat (3) @(posedge clk);
    #2 check_reset("rst_init");
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed cases.
    issue(3'b000, 2'b10, 32'h0, 1'b0, 32'h0000_00A5, 32'h0, 5'd9, 1, 32'h0);
    idle_cycle();
    issue(3'b010, 2'b11, 32'h0, 1'b0, 32'h0000_0010, 32'h0, 5'd3, 3, 32'hDEAD_BEEF);
    issue(3'b101, 2'b00, 32'h40, 1'b1, 32'h0000_0020, 32'h1234, 5'd0, 1, 32'h5555_5555);
    issue(3'b011, 2'b10, 32'h0, 1'b0, 32'h0000_0024, 32'hABCD, 5'd7, 2, 32'h7777_7777);
    issue(3'b010, 2'b11, 32'h0, 1'b0, 32'h0000_0030, 32'h0, 5'd4, TIMEOUT, 32'hCAFE_F00D);
    issue(3'b100, 2'b10, 32'h88, 1'b1, 32'h0000_0001, 32'h0, 5'd2, 1, 32'h0);
    issue(3'b010, 2'b11, 32'h0, 1'b0, 32'h0000_0034, 32'h0, 5'd5, TIMEOUT + 1, 32'h1111_1111);
    issue(3'b010, 2'b11, 32'h0, 1'b0, 32'h0000_0013, 32'h0, 5'd6, 1, 32'h0);
    idle_cycle();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      else begin
        logic [31:0] res;
        int d;
        res = $urandom;
        if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
        case ($urandom_range(0, 9))
          0:       d = TIMEOUT + 1;
          1:       d = TIMEOUT;
          default: d = $urandom_range(1, 5);
        endcase
        issue(3'($urandom), 2'($urandom), $urandom, 1'($urandom), res, $urandom,
              5'($urandom), d, $urandom);
      end
    end
    repeat (3) idle_cycle();

    // Reset during the second access cycle discards the transaction.
    begin
      req_t r;
      @(posedge clk); #1;
      in_valid = 1'b1; in_M = 3'b010; in_WB = 2'b11; in_res = 32'h0000_0050;
      in_dat2 = 32'h0; in_mux = 5'd12; in_flag = 1'b0;
      r.we = 1'b0; r.addr = 32'h50; r.wdata = 32'h0; r.rdata = 32'h9999_9999; r.delay = 10;
      req_q.push_back(r);
      @(posedge clk); #1;
      garbage(1'b0);
      rsp_abort = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      mdl_err = 1'b0;
      mdl_rdata = 32'h0;
      #1 check_reset("rst_mid");
      @(posedge clk); #2 check_reset("rst_held");
      @(posedge clk); #1 rst_n = 1'b1;
    end
    issue(3'b000, 2'b10, 32'h0, 1'b0, 32'h0000_00A5, 32'h0, 5'd9, 1, 32'h0);
    idle_cycle();

    // Drain with a bounded wait.
    k = 0;
    while ((out_q.size() != 0 || br_q.size() != 0 || rsp_busy) && k < 50) begin
      idle_cycle();
      k++;
    end
    repeat (2) idle_cycle();
    chk("out_q_empty", 32'(out_q.size()), 32'd0);
    chk("br_q_empty",  32'(br_q.size()),  32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("mem_req_end", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
